// File: rtl/if_fetch_queue_if.sv
// Fetch-to-decode queue interface: fetch/ID side is master, the queue is slave.
interface if_fetch_queue_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic                  i_valid;
   logic [DATA_WIDTH-1:0] i_PC;
   logic [DATA_WIDTH-1:0] i_Inst;
   logic                  i_ctrl_is_C;
   logic                  i_flush;
   logic                  i_ready;
   logic                  o_ctrl_Busy;
   logic                  o_valid;
   logic [DATA_WIDTH-1:0] o_PC;
   logic [DATA_WIDTH-1:0] o_Inst;
   logic                  o_ctrl_is_C;
   logic [PTR_W:0]        o_count;

   modport master (
      output i_valid, i_PC, i_Inst, i_ctrl_is_C, i_flush, i_ready,
      input  o_ctrl_Busy, o_valid, o_PC, o_Inst, o_ctrl_is_C, o_count
   );

   modport slave (
      input  i_valid, i_PC, i_Inst, i_ctrl_is_C, i_flush, i_ready,
      output o_ctrl_Busy, o_valid, o_PC, o_Inst, o_ctrl_is_C, o_count
   );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch-to-decode decoupling FIFO holding {PC, expanded instruction, compressed flag}.
// Optional IF_FQ_BYPASS_EN: forward the input straight to the head when the queue is empty.
module if_fetch_queue #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input logic             clk,
   input logic             rst,
   if_fetch_queue_if.slave fq
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] inst;
      logic                  is_c;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic full;
   logic empty;
   logic byp;
   logic head_vld;
   logic push;
   logic pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign head_vld = ~empty & ~fq.i_flush;

`ifdef IF_FQ_BYPASS_EN
   assign byp = empty & fq.i_valid & fq.i_ready & ~fq.i_flush;
`else
   assign byp = 1'b0;
`endif

   // A bypassed instruction is consumed directly and never written.
   assign push = fq.i_valid & ~full & ~fq.i_flush & ~byp;
   assign pop  = head_vld & fq.i_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{pc: fq.i_PC, inst: fq.i_Inst, is_c: fq.i_ctrl_is_C};
      end
   end

   always_ff @(posedge clk) begin
      if (rst || fq.i_flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Head presentation: stored entry, forwarded input, or zeros when idle.
   always_comb begin
      fq.o_valid     = 1'b0;
      fq.o_PC        = '0;
      fq.o_Inst      = '0;
      fq.o_ctrl_is_C = 1'b0;
      if (head_vld) begin
         fq.o_valid     = 1'b1;
         fq.o_PC        = mem[rd_ptr].pc;
         fq.o_Inst      = mem[rd_ptr].inst;
         fq.o_ctrl_is_C = mem[rd_ptr].is_c;
      end else if (byp) begin
         fq.o_valid     = 1'b1;
         fq.o_PC        = fq.i_PC;
         fq.o_Inst      = fq.i_Inst;
         fq.o_ctrl_is_C = fq.i_ctrl_is_C;
      end
   end

   assign fq.o_ctrl_Busy = full;
   assign fq.o_count     = count;

endmodule
